// File: rtl/stereo_pkg.sv
// Shared stereo-vision constants plus the result-BRAM arbiter state type
// and its grant-selection function.
package stereo_pkg;

    localparam int IMG_W        = 240;
    localparam int IMG_H        = 320;
    localparam int BLOCK_SIZE   = 6;
    localparam int RESULT_DEPTH = IMG_W * IMG_H;

    // One-hot grant encoding so each ack can be taken straight off a state flop.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_WR = 2'b01,
        GNT_RD = 2'b10
    } arb_state_t;

    function automatic arb_state_t arb_pick(
        input logic wr_req,
        input logic rd_req,
        input logic starved
    );
        arb_state_t pick;
        pick = IDLE;
        if (wr_req && rd_req) begin
            if (starved) begin
                pick = GNT_RD;
            end else begin
                pick = GNT_WR;
            end
        end else if (wr_req) begin
            pick = GNT_WR;
        end else if (rd_req) begin
            pick = GNT_RD;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/disparity_bram_arbiter_if.sv
// Writer, reader, BRAM and status signals of the disparity result-BRAM arbiter.
interface disparity_bram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);

    logic              wr_req_in;
    logic [ADDR_W-1:0] wr_addr_in;
    logic [DATA_W-1:0] wr_data_in;
    logic              wr_ack_out;

    logic              rd_req_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic              rd_ack_out;
    logic              rd_valid_out;
    logic [DATA_W-1:0] rd_data_out;

    logic [ADDR_W-1:0] bram_addr_out;
    logic              bram_we_out;
    logic [DATA_W-1:0] bram_din_out;
    logic [DATA_W-1:0] bram_dout_in;

    logic              err_out;

    modport slave (
        input  wr_req_in, wr_addr_in, wr_data_in,
        input  rd_req_in, rd_addr_in,
        input  bram_dout_in,
        output wr_ack_out, rd_ack_out, rd_valid_out, rd_data_out,
        output bram_addr_out, bram_we_out, bram_din_out,
        output err_out
    );

    modport master (
        output wr_req_in, wr_addr_in, wr_data_in,
        output rd_req_in, rd_addr_in,
        output bram_dout_in,
        input  wr_ack_out, rd_ack_out, rd_valid_out, rd_data_out,
        input  bram_addr_out, bram_we_out, bram_din_out,
        input  err_out
    );

endinterface

// File: rtl/disparity_bram_arbiter_chk.sv
// Invariants of the arbiter outputs: one grant per edge, BRAM writes only
// alongside a write ack, and an error flag that never clears outside reset.
module disparity_bram_arbiter_chk (
    input logic clk_in,
    input logic rst_in,
    input logic wr_ack_in,
    input logic rd_ack_in,
    input logic we_in,
    input logic err_in
);

    a_one_grant: assert property (@(posedge clk_in) disable iff (!rst_in)
        !(wr_ack_in && rd_ack_in));

    a_we_with_ack: assert property (@(posedge clk_in) disable iff (!rst_in)
        we_in |-> wr_ack_in);

    a_err_sticky: assert property (@(posedge clk_in) disable iff (!rst_in)
        err_in |=> err_in);

endmodule

// File: rtl/rd_latency_pipe.sv
// Tracks granted reads through the BRAM latency: a 3-deep shift register of
// valid and out-of-range flags, emptied by reset so in-flight reads vanish.
module rd_latency_pipe (
    input  logic clk_in,
    input  logic rst_in,
    input  logic push_valid_in,
    input  logic push_oor_in,
    output logic valid_out,
    output logic oor_out
);

    logic [2:0] valid_q;
    logic [2:0] valid_d;
    logic [2:0] oor_q;
    logic [2:0] oor_d;

    // Shift one stage per edge; the range flag only travels with a real read.
    always_comb begin
        valid_d = {valid_q[1:0], push_valid_in};
        oor_d   = {oor_q[1:0], push_valid_in & push_oor_in};
    end

    // Pipeline stage registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= 3'b000;
            oor_q   <= 3'b000;
        end else begin
            valid_q <= valid_d;
            oor_q   <= oor_d;
        end
    end

    assign valid_out = valid_q[2];
    assign oor_out   = oor_q[2];

endmodule

// File: rtl/disparity_bram_arbiter.sv
// Arbitrates one writer and one reader onto a single-port result BRAM with
// bounded read starvation, fixed 3-edge read return and a sticky range error.
module disparity_bram_arbiter
    import stereo_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = RESULT_DEPTH,
    parameter int STARVE_MAX = 4
) (
    input logic                     clk_in,
    input logic                     rst_in,
    disparity_bram_arbiter_if.slave bus
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] din_d;
    logic              we_q;
    logic              we_d;
    logic              err_q;
    logic              err_d;
    logic              rd_valid_q;
    logic              rd_valid_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    logic              wr_in_range_s;
    logic              rd_in_range_s;
    logic              gnt_wr_s;
    logic              gnt_rd_s;
    logic              pipe_valid_s;
    logic              pipe_oor_s;

    assign wr_in_range_s = ({1'b0, bus.wr_addr_in} < DEPTH_L);
    assign rd_in_range_s = ({1'b0, bus.rd_addr_in} < DEPTH_L);

    // Next grant from the live requests and the starvation count.
    always_comb begin
        state_d = IDLE;
        state_d = arb_pick(bus.wr_req_in, bus.rd_req_in, starve_q == STARVE_LIM);
    end

    // Arbiter state register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign gnt_wr_s = (state_d == GNT_WR);
    assign gnt_rd_s = (state_d == GNT_RD);

    // Starvation counter and BRAM-side command for the grant being made.
    always_comb begin
        starve_d = {CNT_W{1'b0}};
        addr_d   = addr_q;
        din_d    = din_q;
        we_d     = 1'b0;
        err_d    = err_q;
        case (state_d)
            GNT_WR: begin
                if (!bus.rd_req_in) begin
                    starve_d = {CNT_W{1'b0}};
                end else if (starve_q == STARVE_LIM) begin
                    starve_d = starve_q;
                end else begin
                    starve_d = starve_q + CNT_W'(1);
                end
                // An out-of-range write is acked but never reaches the BRAM.
                if (wr_in_range_s) begin
                    addr_d = bus.wr_addr_in;
                    din_d  = bus.wr_data_in;
                    we_d   = 1'b1;
                end else begin
                    err_d  = 1'b1;
                end
            end
            GNT_RD: begin
                starve_d = {CNT_W{1'b0}};
                if (rd_in_range_s) begin
                    addr_d = bus.rd_addr_in;
                end else begin
                    err_d  = 1'b1;
                end
            end
            default: begin
                starve_d = {CNT_W{1'b0}};
            end
        endcase
    end

    rd_latency_pipe u_rd_pipe (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .push_valid_in (gnt_rd_s),
        .push_oor_in   (~rd_in_range_s),
        .valid_out     (pipe_valid_s),
        .oor_out       (pipe_oor_s)
    );

    // Capture the BRAM word three edges after its grant; out-of-range reads return zero.
    always_comb begin
        rd_valid_d = pipe_valid_s;
        rd_data_d  = rd_data_q;
        if (pipe_valid_s) begin
            if (pipe_oor_s) begin
                rd_data_d = {DATA_W{1'b0}};
            end else begin
                rd_data_d = bus.bram_dout_in;
            end
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            starve_q   <= {CNT_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            din_q      <= {DATA_W{1'b0}};
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DATA_W{1'b0}};
        end else begin
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.wr_ack_out    = state_q[0];
    assign bus.rd_ack_out    = state_q[1];
    assign bus.bram_addr_out = addr_q;
    assign bus.bram_din_out  = din_q;
    assign bus.bram_we_out   = we_q;
    assign bus.err_out       = err_q;
    assign bus.rd_valid_out  = rd_valid_q;
    assign bus.rd_data_out   = rd_data_q;

endmodule

// File: tb/tb_disparity_bram_arbiter.sv
// Directed bench for disparity_bram_arbiter with a 2-cycle-latency BRAM model.
module tb_disparity_bram_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [7:0] mem [0:1023];
    logic [7:0] bram_s1;

    disparity_bram_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus ();

    disparity_bram_arbiter #(
        .ADDR_W(17), .DATA_W(8), .DEPTH(76800), .STARVE_MAX(4)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    disparity_bram_arbiter_chk u_chk (
        .clk_in    (clk),
        .rst_in    (rst_n),
        .wr_ack_in (bus.wr_ack_out),
        .rd_ack_in (bus.rd_ack_out),
        .we_in     (bus.bram_we_out),
        .err_in    (bus.err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM, read-first, address registered then data registered.
    always @(posedge clk) begin
        if (bus.bram_we_out) mem[bus.bram_addr_out[9:0]] <= bus.bram_din_out;
        bram_s1          <= mem[bus.bram_addr_out[9:0]];
        bus.bram_dout_in <= bram_s1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_write(input logic [16:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.wr_req_in  = 1'b1;
        bus.wr_addr_in = addr;
        bus.wr_data_in = data;
        @(negedge clk);
        bus.wr_req_in  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [44:0] outs;
        rst_n = 1'b0;
        bus.wr_req_in = 1'b0; bus.wr_addr_in = '0; bus.wr_data_in = '0;
        bus.rd_req_in = 1'b0; bus.rd_addr_in = '0;
        idle_cycles(2);
        outs = {bus.wr_ack_out, bus.rd_ack_out, bus.rd_valid_out, bus.rd_data_out,
                bus.bram_addr_out, bus.bram_we_out, bus.bram_din_out, bus.err_out};
        checks++;
        if (outs !== 45'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        idle_cycles(2);
        outs = {bus.wr_ack_out, bus.rd_ack_out, bus.rd_valid_out, bus.rd_data_out,
                bus.bram_addr_out, bus.bram_we_out, bus.bram_din_out, bus.err_out};
        checks++;
        if (outs !== 45'd0) begin
            failures++; $display("FAIL post_reset_idle: got %h expected 0", outs);
        end
    endtask

    task automatic test_single_write;
        int acks;
        int wes;
        @(negedge clk);
        bus.wr_req_in = 1'b1; bus.wr_addr_in = 17'd100; bus.wr_data_in = 8'h2A;
        @(negedge clk);
        checks++;
        if ({bus.wr_ack_out, bus.bram_we_out, bus.bram_addr_out, bus.bram_din_out}
            !== {1'b1, 1'b1, 17'd100, 8'h2A}) begin
            failures++;
            $display("FAIL write_grant: got ack=%b we=%b addr=%0d din=%h expected 1 1 100 2a",
                     bus.wr_ack_out, bus.bram_we_out, bus.bram_addr_out, bus.bram_din_out);
        end
        bus.wr_req_in = 1'b0;
        acks = 0; wes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.wr_ack_out) acks++;
            if (bus.bram_we_out) wes++;
        end
        checks++;
        if (acks != 0 || wes != 0) begin
            failures++; $display("FAIL write_single_pulse: got acks=%0d wes=%0d expected 0 0", acks, wes);
        end
        checks++;
        if ({bus.bram_addr_out, bus.bram_din_out} !== {17'd100, 8'h2A}) begin
            failures++;
            $display("FAIL idle_hold: got addr=%0d din=%h expected 100 2a", bus.bram_addr_out, bus.bram_din_out);
        end
    endtask

    task automatic test_write_read;
        int valid_at;
        int valid_cnt;
        logic [7:0] data_seen;
        @(negedge clk);
        bus.rd_req_in = 1'b1; bus.rd_addr_in = 17'd100;
        @(negedge clk);
        checks++;
        if ({bus.rd_ack_out, bus.wr_ack_out, bus.bram_we_out, bus.bram_addr_out}
            !== {1'b1, 1'b0, 1'b0, 17'd100}) begin
            failures++;
            $display("FAIL read_grant: got rdack=%b wrack=%b we=%b addr=%0d expected 1 0 0 100",
                     bus.rd_ack_out, bus.wr_ack_out, bus.bram_we_out, bus.bram_addr_out);
        end
        bus.rd_req_in = 1'b0;
        valid_at = -1; valid_cnt = 0; data_seen = 8'h00;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.rd_valid_out) begin
                valid_cnt++;
                if (valid_at < 0) begin valid_at = i; data_seen = bus.rd_data_out; end
            end
        end
        checks++;
        if (valid_at != 3 || valid_cnt != 1) begin
            failures++; $display("FAIL read_latency: got at=%0d count=%0d expected 3 1", valid_at, valid_cnt);
        end
        checks++;
        if (data_seen !== 8'h2A) begin
            failures++; $display("FAIL read_data: got %h expected 2a", data_seen);
        end
    endtask

    task automatic test_contention;
        logic [1:0] got;
        logic [1:0] exp;
        @(negedge clk);
        bus.wr_req_in = 1'b1; bus.wr_addr_in = 17'd200; bus.wr_data_in = 8'h11;
        bus.rd_req_in = 1'b1; bus.rd_addr_in = 17'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            got = {bus.rd_ack_out, bus.wr_ack_out};
            exp = ((i % 5) == 4) ? 2'b10 : 2'b01;
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL contention_edge%0d: got %b expected %b", i + 1, got, exp);
            end
        end
        bus.wr_req_in = 1'b0; bus.rd_req_in = 1'b0;
        idle_cycles(5);
    endtask

    task automatic test_drop_out;
        int rd_acks;
        int valids;
        @(negedge clk);
        bus.wr_req_in = 1'b1; bus.wr_addr_in = 17'd201; bus.wr_data_in = 8'h12;
        bus.rd_req_in = 1'b1; bus.rd_addr_in = 17'd6;
        @(negedge clk);
        checks++;
        if ({bus.wr_ack_out, bus.rd_ack_out} !== 2'b10) begin
            failures++; $display("FAIL dropout_first: got wr=%b rd=%b expected 1 0", bus.wr_ack_out, bus.rd_ack_out);
        end
        bus.wr_req_in = 1'b0; bus.rd_req_in = 1'b0;
        rd_acks = 0; valids = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rd_ack_out) rd_acks++;
            if (bus.rd_valid_out) valids++;
        end
        checks++;
        if (rd_acks != 0 || valids != 0) begin
            failures++; $display("FAIL dropout_no_grant: got acks=%0d valids=%0d expected 0 0", rd_acks, valids);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_ack;
        logic exp_v;
        logic [7:0] exp_d;
        for (int a = 0; a < 4; a++) drive_write(17'(a), 8'hA0 + 8'(a));
        idle_cycles(2);
        @(negedge clk);
        bus.rd_req_in = 1'b1; bus.rd_addr_in = 17'd0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            exp_ack = (j <= 4);
            exp_v   = (j >= 4) && (j <= 7);
            exp_d   = 8'hA0 + 8'(j - 4);
            checks++;
            if (bus.rd_ack_out !== exp_ack) begin
                failures++; $display("FAIL b2b_ack%0d: got %b expected %b", j, bus.rd_ack_out, exp_ack);
            end
            checks++;
            if (bus.rd_valid_out !== exp_v) begin
                failures++; $display("FAIL b2b_valid%0d: got %b expected %b", j, bus.rd_valid_out, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (bus.rd_data_out !== exp_d) begin
                    failures++; $display("FAIL b2b_data%0d: got %h expected %h", j, bus.rd_data_out, exp_d);
                end
            end
            if (j < 4) bus.rd_addr_in = 17'(j);
            else bus.rd_req_in = 1'b0;
        end
    endtask

    task automatic test_out_of_range;
        logic [16:0] addr_before;
        int valid_at;
        logic [7:0] data_seen;
        checks++;
        if (bus.err_out !== 1'b0) begin
            failures++; $display("FAIL err_clear: got %b expected 0", bus.err_out);
        end
        @(negedge clk);
        bus.wr_req_in = 1'b1; bus.wr_addr_in = 17'd76800; bus.wr_data_in = 8'h77;
        @(negedge clk);
        checks++;
        if ({bus.wr_ack_out, bus.bram_we_out, bus.err_out} !== 3'b101) begin
            failures++;
            $display("FAIL oor_write: got ack=%b we=%b err=%b expected 1 0 1",
                     bus.wr_ack_out, bus.bram_we_out, bus.err_out);
        end
        bus.wr_req_in = 1'b0;
        idle_cycles(2);
        addr_before = bus.bram_addr_out;
        bus.rd_req_in = 1'b1; bus.rd_addr_in = 17'd76800;
        @(negedge clk);
        checks++;
        if ({bus.rd_ack_out, bus.bram_addr_out} !== {1'b1, addr_before}) begin
            failures++;
            $display("FAIL oor_read_grant: got ack=%b addr=%0d expected 1 %0d",
                     bus.rd_ack_out, bus.bram_addr_out, addr_before);
        end
        bus.rd_req_in = 1'b0;
        valid_at = -1; data_seen = 8'hFF;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.rd_valid_out && valid_at < 0) begin valid_at = i; data_seen = bus.rd_data_out; end
        end
        checks++;
        if (valid_at != 3 || data_seen !== 8'h00) begin
            failures++; $display("FAIL oor_read_return: got at=%0d data=%h expected 3 00", valid_at, data_seen);
        end
        checks++;
        if (bus.err_out !== 1'b1) begin
            failures++; $display("FAIL err_sticky: got %b expected 1", bus.err_out);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [44:0] outs;
        int bad;
        @(negedge clk);
        bus.rd_req_in = 1'b1; bus.rd_addr_in = 17'd2;
        @(negedge clk);
        checks++;
        if (bus.rd_ack_out !== 1'b1) begin
            failures++; $display("FAIL midrst_ack: got %b expected 1", bus.rd_ack_out);
        end
        bus.rd_req_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        outs = {bus.wr_ack_out, bus.rd_ack_out, bus.rd_valid_out, bus.rd_data_out,
                bus.bram_addr_out, bus.bram_we_out, bus.bram_din_out, bus.err_out};
        checks++;
        if (outs !== 45'd0) begin
            failures++; $display("FAIL midrst_async_clear: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            outs = {bus.wr_ack_out, bus.rd_ack_out, bus.rd_valid_out, bus.rd_data_out,
                    bus.bram_addr_out, bus.bram_we_out, bus.bram_din_out, bus.err_out};
            if (outs !== 45'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL midrst_no_return: got %0d nonzero cycles expected 0", bad);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_write();
        test_write_read();
        test_contention();
        test_drop_out();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
